// File: rtl/bcd_snapshot_streamer_pkg.sv
// Shared BCD types and FSM states for the snapshot streamer and the downstream
// bcd_to_gray stage.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic {IDLE, SEND} snap_state_t;

endpackage

// File: rtl/bcd_snapshot_streamer_digit_cell.sv
// One BCD digit position of the up/down counter: next-digit value plus the
// carry/borrow passed to the next more-significant digit.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       cin_i,
    input  logic       bin_i,
    output bcd_digit_t digit_o,
    output logic       cout_o,
    output logic       bout_o
);

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        bout_o  = 1'b0;
        if (up_i && cin_i) begin
            if (digit_i >= BCD_MAX) begin
                digit_o = '0;
                cout_o  = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (down_i && bin_i) begin
            if (digit_i == '0) begin
                digit_o = BCD_MAX;
                bout_o  = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_snapshot_streamer.sv
// Multi-digit BCD up/down counter that snapshots its value on request and
// streams the snapshot LSD-first over a valid/ready handshake.
module bcd_snapshot_streamer
    import bcd_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    input  logic          snap,
    output logic          busy,
    output logic          bcd_valid,
    input  logic          bcd_ready,
    output logic [3:0]    bcd,
    output logic [IW-1:0] bcd_idx,
    output logic          bcd_last,
    output logic          ovf,
    output logic          unf
);

    bcd_digit_t  count_q  [DIGITS];
    bcd_digit_t  count_d  [DIGITS];
    bcd_digit_t  count_nx [DIGITS];
    bcd_digit_t  shadow_q [DIGITS];
    bcd_digit_t  shadow_d [DIGITS];
    snap_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic        up, down;
    logic [DIGITS:0] carry;
    logic [DIGITS:0] borrow;
    logic        at_last;

    // inc and dec together cancel, so neither chain is started
    assign up        = inc & ~dec;
    assign down      = dec & ~inc;
    assign carry[0]  = up;
    assign borrow[0] = down;

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_digit_cell u_cell (
            .digit_i (count_q[g]),
            .up_i    (up),
            .down_i  (down),
            .cin_i   (carry[g]),
            .bin_i   (borrow[g]),
            .digit_o (count_nx[g]),
            .cout_o  (carry[g+1]),
            .bout_o  (borrow[g+1])
        );
    end

    always_comb begin
        count_d = count_nx;
        ovf_d   = ovf_q | carry[DIGITS];
        unf_d   = unf_q | borrow[DIGITS];
        if (clr) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                count_d[i] = '0;
            end
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    assign at_last = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                // shadow takes the pre-update count, independent of inc/dec this cycle
                if (snap) begin
                    shadow_d = count_q;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bcd_ready) begin
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                count_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign busy      = (state_q == SEND);
    assign bcd_valid = busy;
    assign bcd       = busy ? shadow_q[idx_q] : '0;
    assign bcd_idx   = idx_q;
    assign bcd_last  = busy & at_last;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_bcd_snapshot_streamer.sv
// Directed bench for bcd_snapshot_streamer: integer-arithmetic reference model
// compared every cycle, plus literal digit sequences per scenario.
module tb_bcd_snapshot_streamer;

    localparam int D    = 4;
    localparam int MAXV = 9999;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc = 1'b0, dec = 1'b0, clr = 1'b0, snap = 1'b0;
    logic       bcd_ready = 1'b0;
    logic       busy, bcd_valid, bcd_last, ovf, unf;
    logic [3:0] bcd;
    logic [1:0] bcd_idx;

    bcd_snapshot_streamer #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .dec       (dec),
        .clr       (clr),
        .snap      (snap),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .bcd       (bcd),
        .bcd_idx   (bcd_idx),
        .bcd_last  (bcd_last),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_en = 1'b0;

    int m_count, m_shadow, m_pos;
    bit m_busy, m_ovf, m_unf;

    int acc[$];
    int lacc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_digit();
        return (m_shadow / (10 ** m_pos)) % 10;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_shadow = 0; m_pos = 0;
            m_busy = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (m_busy) begin
                if (bcd_ready) begin
                    if (m_pos == D - 1) begin
                        m_busy = 1'b0;
                        m_pos  = 0;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (snap) begin
                m_shadow = m_count;
                m_pos    = 0;
                m_busy   = 1'b1;
            end
            if (clr) begin
                m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
            end else if (inc && !dec) begin
                if (m_count == MAXV) begin m_count = 0; m_ovf = 1'b1; end
                else m_count++;
            end else if (dec && !inc) begin
                if (m_count == 0) begin m_count = MAXV; m_unf = 1'b1; end
                else m_count--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("busy",  32'(busy),      32'(m_busy));
            chk("valid", 32'(bcd_valid), 32'(m_busy));
            chk("bcd",   32'(bcd),       m_busy ? m_digit() : 0);
            chk("idx",   32'(bcd_idx),   m_busy ? m_pos : 0);
            chk("last",  32'(bcd_last),  32'(m_busy && m_pos == D - 1));
            chk("ovf",   32'(ovf),       32'(m_ovf));
            chk("unf",   32'(unf),       32'(m_unf));
        end
    end

    always @(negedge clk) begin
        if (rst_n && bcd_valid && bcd_ready) begin
            acc.push_back(int'(bcd));
            lacc.push_back(int'(bcd_last));
        end
    end

    always @(negedge clk) begin
        assert (bcd <= 4'd9) else $error("bcd digit out of range: %0d", bcd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic i, input logic d, input logic c, input logic s);
        inc = i; dec = d; clr = c; snap = s;
        tick();
        inc = 1'b0; dec = 1'b0; clr = 1'b0; snap = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic expect_digits(input string name, input int e0, input int e1,
                                 input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_count"}, acc.size(), 4);
        for (int i = 0; i < 4 && i < acc.size(); i++) chk(name, acc[i], e[i]);
    endtask

    task automatic stream(input string name, input int e0, input int e1,
                          input int e2, input int e3);
        acc.delete();
        lacc.delete();
        bcd_ready = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle(20);
        expect_digits(name, e0, e1, e2, e3);
    endtask

    initial begin
        int pat[4];
        int c;
        pat = '{1, 0, 0, 1};

        // reset state
        #12;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_valid", 32'(bcd_valid), 0);
        chk("rst_bcd",   32'(bcd), 0);
        chk("rst_idx",   32'(bcd_idx), 0);
        chk("rst_last",  32'(bcd_last), 0);
        chk("rst_flags", 32'({ovf, unf}), 0);
        tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // 1234 increments then stream
        repeat (1234) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        stream("s1234", 4, 3, 2, 1);
        for (int i = 0; i < 4 && i < lacc.size(); i++)
            chk("s1234_last", lacc[i], (i == 3) ? 1 : 0);
        chk("s1234_busy_done", 32'(busy), 0);

        // wrap at 9999 and 0000
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (9999) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        stream("s9999", 9, 9, 9, 9);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_ovf", 32'(ovf), 1);
        chk("wrap_unf0", 32'(unf), 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_unf", 32'(unf), 1);
        stream("sdec", 9, 9, 9, 9);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        stream("sboth", 9, 9, 9, 9);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_flags", 32'({ovf, unf}), 0);
        stream("sclr", 0, 0, 0, 0);

        // inc coincident with snap
        repeat (59) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        acc.delete(); lacc.delete();
        bcd_ready = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        wait_idle(20);
        expect_digits("s0059", 9, 5, 0, 0);
        stream("s0060", 0, 6, 0, 0);

        // back-pressure
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (12) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        acc.delete(); lacc.delete();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        c = 0;
        while (busy && c < 40) begin
            bcd_ready = (pat[c % 4] != 0);
            tick();
            c++;
        end
        chk("stall_cycles", c, 8);
        expect_digits("s0012_stall", 2, 1, 0, 0);

        // counter activity and ignored snap during SEND
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (7) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        acc.delete(); lacc.delete();
        bcd_ready = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        bcd_ready = 1'b1;
        wait_idle(20);
        expect_digits("s0007_busy", 7, 0, 0, 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        stream("s_postclr", 2, 0, 0, 0);

        // asynchronous reset mid-stream
        repeat (10) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        bcd_ready = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(busy), 0);
        chk("arst_valid", 32'(bcd_valid), 0);
        chk("arst_bcd",   32'(bcd), 0);
        chk("arst_idx",   32'(bcd_idx), 0);
        chk("arst_last",  32'(bcd_last), 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_idle", 32'(busy), 0);
        stream("s_afterrst", 0, 0, 0, 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

endmodule
